uart_rx_front: RTL and testbench

Serial receive front end for the `tt_um_main` core. It takes the asynchronous UART line from a dedicated input pin and recovers 8N1 bytes by mid-bit sampling. Recovered bytes are buffered in a small FIFO and presented to the core's command logic over a valid/ready stream. It is the stage directly upstream of the core's byte consumer.

---
 rtl/uart_rx_front.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_front.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_front.sv
// UART 8N1 receiver front end: 2-flop synchronizer, mid-bit sampling FSM and byte FIFO.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_front #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          rx,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] HALF_TICKS = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TICKS = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rxs_q, rxs_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  logic push, pop, full, push_ok, tick_zero;

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rxs_d       = rx_meta_q;
    tick_d      = tick_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    tick_zero   = (tick_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          tick_d  = HALF_TICKS;
        end
      end
      S_START: begin
        if (!tick_zero) begin
          tick_d = tick_q - TW'(1);
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          tick_d  = FULL_TICKS;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (!tick_zero) begin
          tick_d = tick_q - TW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          tick_d  = FULL_TICKS;
          idx_d   = idx_q + 3'(1);
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tick_zero) begin
          tick_d = tick_q - TW'(1);
        end else begin
          par_err_d = rxs_q ^ (^shift_q);
          tick_d    = FULL_TICKS;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tick_zero) begin
          tick_d = tick_q - TW'(1);
        end else begin
`ifdef UART_RX_PARITY_EN
          if (rxs_q && !par_err_q) push = 1'b1;
          else                     frame_err_d = 1'b1;
`else
          if (rxs_q) push = 1'b1;
          else       frame_err_d = 1'b1;
`endif
          state_d = rxs_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling abandons any partial frame but leaves buffered bytes drainable.
    if (!ena) begin
      state_d     = S_IDLE;
      push        = 1'b0;
      frame_err_d = 1'b0;
    end

    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = (count_q != '0) && m_ready;
    push_ok = push && (!full || pop);

    if (push && !push_ok) overflow_d = 1'b1;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      tick_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign m_data     = mem_q[rd_ptr_q];
  assign m_valid    = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_front.sv
// Self-checking bench for uart_rx_front: frame-level schedule model plus directed literal checks.
module tb_uart_rx_front;
  localparam int C     = 16;
  localparam int H     = C / 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NPOST = 10;
`else
  localparam int NPOST = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       rx = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  uart_rx_front #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rx(rx),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A frame becomes visible at an absolute edge number derived from the line timing:
  // 2 synchronizer edges + 1 detect edge + half bit + NPOST whole bits after the start edge.
  typedef struct {
    int         edge_n;
    logic [7:0] data;
    bit         good;
  } ev_t;
  ev_t sched[$];

  logic [7:0] mq[$];
  bit   en_cmp = 1'b0;
  bit   p_rst = 1'b0;
  bit   p_pop = 1'b0;
  bit   p_ev  = 1'b0;
  ev_t  p_e;
  bit   e_ferr, e_ovf, was_full;

  always @(negedge clk) begin
    e_ferr = 1'b0;
    e_ovf  = 1'b0;
    if (p_rst) begin
      mq.delete();
      en_cmp = 1'b1;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (p_pop) void'(mq.pop_front());
      if (p_ev) begin
        if (!p_e.good)              e_ferr = 1'b1;
        else if (was_full && !p_pop) e_ovf = 1'b1;
        else                         mq.push_back(p_e.data);
      end
    end
    if (en_cmp) begin
      check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
      check("frame_err", 32'(frame_err), 32'(e_ferr));
      check("overflow", 32'(overflow), 32'(e_ovf));
    end
    p_rst = rst;
    p_pop = (mq.size() != 0) && m_ready;
    p_ev  = 1'b0;
    while (sched.size() != 0 && sched[0].edge_n <= cyc + 1) begin
      if (sched[0].edge_n == cyc + 1) begin
        p_e  = sched[0];
        p_ev = 1'b1;
      end
      void'(sched.pop_front());
    end
  end

  logic [7:0] got[$];
  int nferr = 0;
  int novf  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (frame_err) nferr++;
      if (overflow)  novf++;
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    e.edge_n = cyc + 3 + H + NPOST * C;
    e.data   = b;
    e.good   = stop_bit;
    sched.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic clear_obs();
    got.delete();
    nferr = 0;
    novf  = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  bit rand_ready;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset m_valid", 32'(m_valid), 0);
    check("reset fifo_count", 32'(fifo_count), 0);
    check("reset m_data", 32'(m_data), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset overflow", 32'(overflow), 0);
    drive_bit(1'b1);

    // Single byte, consumer always ready
    clear_obs();
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);
    check("a5 count", 32'(got.size()), 1);
    if (got.size() == 1) check("a5 byte", 32'(got[0]), 32'h a5);
    check("a5 fifo_count", 32'(fifo_count), 0);
    check("a5 ferr", 32'(nferr), 0);
    check("a5 ovf", 32'(novf), 0);

    // Short low glitch shorter than half a bit
    clear_obs();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) drive_bit(1'b1);
    check("glitch pushes", 32'(got.size()), 0);
    check("glitch ferr", 32'(nferr), 0);

    // Bad stop then long break, then a clean byte
    clear_obs();
    send_frame(8'h3C, 1'b0);
    repeat (40) drive_bit(1'b0);
    repeat (2) drive_bit(1'b1);
    check("break ferr", 32'(nferr), 1);
    check("break pushes", 32'(got.size()), 0);
    send_frame(8'h11, 1'b1);
    drive_bit(1'b1);
    check("after break count", 32'(got.size()), 1);
    if (got.size() == 1) check("after break byte", 32'(got[0]), 32'h11);

    // Overflow with consumer stalled
    clear_obs();
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    drive_bit(1'b1);
    check("ovf fifo_count", 32'(fifo_count), 4);
    check("ovf pulses", 32'(novf), 1);
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("ovf drained", 32'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("ovf drain order", 32'(got[i]), 32'(i + 1));

    // Full FIFO with a pop landing on the 5th stop sample
    clear_obs();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        int t;
        t = cyc + 3 + H + NPOST * C;
        while (cyc < t - 1) begin
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
      end
    join
    drive_bit(1'b1);
    check("pop-push ovf", 32'(novf), 0);
    check("pop-push fifo_count", 32'(fifo_count), 4);
    check("pop-push head", 32'(m_data), 32'h02);
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("pop-push total", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("pop-push order", 32'(got[i]), 32'(i + 1));

    // Reset in the middle of bit 3 of 0x7E with bytes buffered
    send_frame(8'hAA, 1'b1);
    send_frame(8'h55, 1'b1);
    clear_obs();
    begin
      logic [7:0] b;
      b = 8'h7E;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      rx = b[3];
      repeat (H) @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst m_valid", 32'(m_valid), 0);
    check("rst fifo_count", 32'(fifo_count), 0);
    check("rst m_data", 32'(m_data), 0);
    check("rst frame_err", 32'(frame_err), 0);
    check("rst overflow", 32'(overflow), 0);
    m_ready = 1'b1;
    repeat (12) drive_bit(1'b1);
    check("rst no push", 32'(got.size()), 0);
    check("rst no ferr", 32'(nferr), 0);

    // ena low mid-frame keeps FIFO, drops the partial frame
    clear_obs();
    m_ready = 1'b0;
    send_frame(8'h66, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    ena = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;
    repeat (12) drive_bit(1'b1);
    check("ena fifo_count", 32'(fifo_count), 1);
    check("ena head", 32'(m_data), 32'h66);
    check("ena ferr", 32'(nferr), 0);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic, bursty consumer, occasional bad stop bits
    rand_ready = 1'b1;
    fork
      begin
        while (rand_ready) begin
          m_ready = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 1200)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] b;
          bit bad;
          int gap;
          b   = 8'($urandom);
          bad = ($urandom_range(0, 7) == 0);
          send_frame(b, !bad);
          gap = $urandom_range(bad ? 1 : 0, 2);
          repeat (gap) drive_bit(1'b1);
        end
        rand_ready = 1'b0;
      end
    join
    m_ready = 1'b1;
    repeat (2) drive_bit(1'b1);
    check("final fifo_count", 32'(fifo_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
